// File: rtl/aes_gcm_pkg.sv
// Shared GF(2^128) types, constants and helpers for the AES-GCM datapath.
// Block vectors are [0:127] with bit 0 holding the GCM most-significant bit,
// so a GCM "right shift" moves bits toward higher indices.
package aes_gcm_pkg;

    typedef logic [0:127] gf_block_t;

    // Reduction constant: x^128 = x^7 + x^2 + x + 1, bit-reflected.
    localparam gf_block_t GF_R    = {8'hE1, 120'b0};
    localparam gf_block_t GF_ZERO = {128{1'b0}};

    // FSM states of the iterative GHASH engine.
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } ghash_state_t;

    // One V update of the right-shift multiply: V * x, reduced mod P(x).
    function automatic gf_block_t gf_shift_r(input gf_block_t v);
        gf_block_t s;
        s = {1'b0, v[0:126]};
        if (v[127]) begin
            gf_shift_r = s ^ GF_R;
        end else begin
            gf_shift_r = s;
        end
    endfunction

endpackage

// File: rtl/gf128_digit_step.sv
// Combinational digit of the GF(2^128) right-shift multiplier.
// Consumes DIGIT_W multiplier bits, most significant (index 0) first,
// updating the partial product Z and the shifted multiplicand V.
module gf128_digit_step
    import aes_gcm_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  gf_block_t            z_i,
    input  gf_block_t            v_i,
    input  logic [0:DIGIT_W-1]   a_i,
    output gf_block_t            z_o,
    output gf_block_t            v_o
);

    gf_block_t z_s;
    gf_block_t v_s;

    // Chain DIGIT_W single-bit steps: conditional accumulate, then shift V.
    always_comb begin
        z_s = z_i;
        v_s = v_i;
        for (int j = 0; j < DIGIT_W; j++) begin
            if (a_i[j]) begin
                z_s = z_s ^ v_s;
            end else begin
                z_s = z_s;
            end
            v_s = gf_shift_r(v_s);
        end
    end

    assign z_o = z_s;
    assign v_o = v_s;

endmodule

// File: rtl/ghash_stream.sv
// Iterative GHASH engine: accumulates Y_i = (Y_{i-1} ^ X_i) * H over a
// stream of 128-bit blocks and emits tag = Y_final ^ E_K(J0) on the last
// block. DIGIT_W multiplier bits are processed per cycle, so each block
// occupies 128/DIGIT_W multiply cycles plus one idle/accept cycle.
module ghash_stream
    import aes_gcm_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic [0:127]  i_h,
    input  logic          i_h_load,
    input  logic [0:127]  i_x,
    input  logic          i_valid,
    input  logic          i_last,
    input  logic [0:127]  i_ek0,
    output logic          o_ready,
    output logic [0:127]  o_tag,
    output logic          o_tag_valid,
    output logic          o_busy
);

    localparam int CYCLES = 128 / DIGIT_W;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_ZERO | 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    ghash_state_t     state_q, state_d;
    gf_block_t        h_q, h_d;
    gf_block_t        y_q, y_d;
    gf_block_t        a_q, a_d;
    gf_block_t        z_q, z_d;
    gf_block_t        v_q, v_d;
    gf_block_t        ek0_q, ek0_d;
    gf_block_t        tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             tag_valid_q, tag_valid_d;

    gf_block_t        z_step_s;
    gf_block_t        v_step_s;

    // A is shifted toward index 0 each cycle, so the current digit is
    // always its leading DIGIT_W bits.
    gf128_digit_step #(
        .DIGIT_W (DIGIT_W)
    ) u_step (
        .z_i (z_q),
        .v_i (v_q),
        .a_i (a_q[0:DIGIT_W-1]),
        .z_o (z_step_s),
        .v_o (v_step_s)
    );

    // Next-state logic: key load / accept in IDLE, digit multiply in MUL.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        y_d         = y_q;
        a_d         = a_q;
        z_d         = z_q;
        v_d         = v_q;
        ek0_d       = ek0_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        tag_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_h_load) begin
                    // A key load takes priority over a simultaneous beat.
                    h_d     = i_h;
                    y_d     = GF_ZERO;
                    state_d = IDLE;
                end else if (i_valid) begin
                    a_d     = y_q ^ i_x;
                    z_d     = GF_ZERO;
                    v_d     = h_q;
                    cnt_d   = CNT_ZERO;
                    last_d  = i_last;
                    state_d = MUL;
                    if (i_last) begin
                        ek0_d = i_ek0;
                    end else begin
                        ek0_d = ek0_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                a_d   = a_q << DIGIT_W;
                z_d   = z_step_s;
                v_d   = v_step_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    if (last_q) begin
                        // Message complete: publish tag and restart the hash.
                        tag_d       = z_step_s ^ ek0_q;
                        tag_valid_d = 1'b1;
                        y_d         = GF_ZERO;
                    end else begin
                        y_d = z_step_s;
                    end
                end else begin
                    state_d = MUL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            h_q         <= GF_ZERO;
            y_q         <= GF_ZERO;
            a_q         <= GF_ZERO;
            z_q         <= GF_ZERO;
            v_q         <= GF_ZERO;
            ek0_q       <= GF_ZERO;
            tag_q       <= GF_ZERO;
            cnt_q       <= CNT_ZERO;
            last_q      <= 1'b0;
            tag_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            y_q         <= y_d;
            a_q         <= a_d;
            z_q         <= z_d;
            v_q         <= v_d;
            ek0_q       <= ek0_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    // Ready drops during a key load so a coincident beat is held off.
    assign o_ready     = (state_q == IDLE) && !i_h_load;
    assign o_busy      = (state_q == MUL);
    assign o_tag       = tag_q;
    assign o_tag_valid = tag_valid_q;

endmodule

// File: tb/tb_ghash_stream.sv
// Self-checking bench for ghash_stream. Three instances (DIGIT_W = 1, 8, 128)
// share data/key/reset inputs and have separate valid lines. Expected tags
// come from a polynomial-arithmetic GF(2^128) model and NIST GCM vectors.
module tb_ghash_stream;
    import aes_gcm_pkg::*;

    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [0:127] h = '0;
    logic         h_load = 1'b0;
    logic [0:127] x = '0;
    logic         last = 1'b0;
    logic [0:127] ek0 = '0;
    logic         vld  [NI] = '{1'b0, 1'b0, 1'b0};
    logic         rdy  [NI];
    logic [0:127] tag  [NI];
    logic         tv   [NI];
    logic         busy [NI];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [0:127] tlog [NI][256];
    int           tcyc [NI][256];
    int           tn   [NI] = '{0, 0, 0};
    int           tbase[NI];
    logic [0:127] msg  [8];

    localparam logic [0:127] NIST_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [0:127] NIST_EK  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [0:127] NIST_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [0:127] NIST_LEN = 128'h00000000000000000000000000000080;
    localparam logic [0:127] NIST_T2  = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [0:127] NIST_Y2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam logic [0:127] ONE_H    = 128'h80000000000000000000000000000000;

    always #5 clk = ~clk;

    ghash_stream #(.DIGIT_W(1)) u_dw1 (
        .clk(clk), .i_reset(rst), .i_h(h), .i_h_load(h_load), .i_x(x),
        .i_valid(vld[0]), .i_last(last), .i_ek0(ek0), .o_ready(rdy[0]),
        .o_tag(tag[0]), .o_tag_valid(tv[0]), .o_busy(busy[0]));
    ghash_stream #(.DIGIT_W(8)) u_dw8 (
        .clk(clk), .i_reset(rst), .i_h(h), .i_h_load(h_load), .i_x(x),
        .i_valid(vld[1]), .i_last(last), .i_ek0(ek0), .o_ready(rdy[1]),
        .o_tag(tag[1]), .o_tag_valid(tv[1]), .o_busy(busy[1]));
    ghash_stream #(.DIGIT_W(128)) u_dw128 (
        .clk(clk), .i_reset(rst), .i_h(h), .i_h_load(h_load), .i_x(x),
        .i_valid(vld[2]), .i_last(last), .i_ek0(ek0), .o_ready(rdy[2]),
        .o_tag(tag[2]), .o_tag_valid(tv[2]), .o_busy(busy[2]));

    // Free-running cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Log every tag pulse with the cycle in which it was seen.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (tv[k]) begin
                tlog[k][tn[k] % 256] <= tag[k];
                tcyc[k][tn[k] % 256] <= cyc;
                tn[k]                <= tn[k] + 1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int dw_of(input int k);
        case (k)
            0:       dw_of = 1;
            1:       dw_of = 8;
            default: dw_of = 128;
        endcase
    endfunction

    function automatic logic [0:127] rnd128();
        rnd128 = {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // GF(2^128) product as plain polynomial multiply then reduction;
    // index i is the coefficient of x^i.
    function automatic logic [0:127] ref_mul(input logic [0:127] a, input logic [0:127] b);
        logic [0:254] p;
        p = '0;
        for (int i = 0; i < 128; i++)
            if (a[i]) p[i +: 128] = p[i +: 128] ^ b;
        for (int d = 254; d >= 128; d--) begin
            if (p[d]) begin
                p[d]       = 1'b0;
                p[d - 128] = ~p[d - 128];
                p[d - 127] = ~p[d - 127];
                p[d - 126] = ~p[d - 126];
                p[d - 121] = ~p[d - 121];
            end
        end
        ref_mul = p[0:127];
    endfunction

    function automatic logic [0:127] ref_tag(input logic [0:127] hv, input int n, input logic [0:127] ekv);
        logic [0:127] y;
        y = '0;
        for (int i = 0; i < n; i++) y = ref_mul(y ^ msg[i], hv);
        ref_tag = y ^ ekv;
    endfunction

    function automatic bit all_ready(input logic [NI-1:0] m);
        bit r;
        r = 1'b1;
        for (int k = 0; k < NI; k++) if (m[k] && rdy[k] !== 1'b1) r = 1'b0;
        all_ready = r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int k = 0; k < NI; k++) tbase[k] = tn[k];
    endtask

    task automatic load_h(input logic [0:127] hv);
        h = hv; h_load = 1'b1;
        tick();
        h_load = 1'b0; h = rnd128();
    endtask

    // Wait for all masked instances to be ready, then present one beat.
    task automatic send_beat(input logic [0:127] bx, input logic bl, input logic [0:127] be,
                             input logic [NI-1:0] m, output int acc, output bit ok);
        int g;
        g = 0;
        while (!all_ready(m) && g < 400) begin tick(); g++; end
        ok = (g < 400);
        x = bx; last = bl; ek0 = be;
        for (int k = 0; k < NI; k++) vld[k] = m[k];
        tick();
        acc = cyc;
        for (int k = 0; k < NI; k++) vld[k] = 1'b0;
        x = rnd128(); last = 1'($urandom_range(1)); ek0 = rnd128();
    endtask

    task automatic send_msg(input int n, input logic [0:127] ekv, input logic [NI-1:0] m,
                            output int acc, output bit ok);
        bit bok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_beat(msg[i], (i == n - 1), ekv, m, acc, bok);
            if (!bok) ok = 1'b0;
        end
    endtask

    task automatic wait_tags(input logic [NI-1:0] m, output bit ok);
        int g;
        g = 0; ok = 1'b0;
        while (!ok && g < 400) begin
            ok = 1'b1;
            for (int k = 0; k < NI; k++) if (m[k] && tn[k] < tbase[k] + 1) ok = 1'b0;
            if (!ok) begin tick(); g++; end
        end
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (rdy[k] !== 1'b1) $display("FAIL reset_ready dw%0d: got %b want 1", dw_of(k), rdy[k]); else n_pass++;
            n_total++;
            if (busy[k] !== 1'b0) $display("FAIL reset_busy dw%0d: got %b want 0", dw_of(k), busy[k]); else n_pass++;
            n_total++;
            if (tv[k] !== 1'b0) $display("FAIL reset_tag_valid dw%0d: got %b want 0", dw_of(k), tv[k]); else n_pass++;
            n_total++;
            if (tag[k] !== 128'h0) $display("FAIL reset_tag dw%0d: got %h want 0", dw_of(k), tag[k]); else n_pass++;
        end
    endtask

    task automatic test_unit_element();
        int acc; bit ok;
        load_h(ONE_H);
        msg[0] = NIST_C;
        snap();
        send_msg(1, 128'h0, 3'b111, acc, ok);
        wait_tags(3'b111, ok);
        n_total++;
        if (!ok) $display("FAIL unit_timeout: no tag within bound"); else n_pass++;
        for (int k = 0; k < NI; k++) begin
            int idx;
            idx = tbase[k] % 256;
            n_total++;
            if (tn[k] - tbase[k] !== 1) $display("FAIL unit_pulses dw%0d: got %0d want 1", dw_of(k), tn[k] - tbase[k]); else n_pass++;
            n_total++;
            if (tlog[k][idx] !== NIST_C) $display("FAIL unit_tag dw%0d: got %h want %h", dw_of(k), tlog[k][idx], NIST_C); else n_pass++;
            n_total++;
            if (tcyc[k][idx] - acc !== 128 / dw_of(k))
                $display("FAIL unit_latency dw%0d: got %0d want %0d", dw_of(k), tcyc[k][idx] - acc, 128 / dw_of(k));
            else n_pass++;
            n_total++;
            if (tag[k] !== NIST_C || tv[k] !== 1'b0)
                $display("FAIL unit_hold dw%0d: got tag %h valid %b want %h 0", dw_of(k), tag[k], tv[k], NIST_C);
            else n_pass++;
        end
    endtask

    task automatic test_nist1();
        int acc; bit ok;
        load_h(NIST_H);
        msg[0] = 128'h0;
        snap();
        send_msg(1, NIST_EK, 3'b111, acc, ok);
        wait_tags(3'b111, ok);
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (tlog[k][tbase[k] % 256] !== NIST_EK || tn[k] - tbase[k] !== 1)
                $display("FAIL nist1_tag dw%0d: got %h (%0d tags) want %h", dw_of(k), tlog[k][tbase[k] % 256], tn[k] - tbase[k], NIST_EK);
            else n_pass++;
        end
    endtask

    task automatic test_nist2();
        int acc; bit ok;
        load_h(NIST_H);
        msg[0] = NIST_C; msg[1] = NIST_LEN;
        snap();
        send_msg(2, NIST_EK, 3'b111, acc, ok);
        wait_tags(3'b111, ok);
        for (int k = 0; k < NI; k++) begin
            logic [0:127] got;
            got = tlog[k][tbase[k] % 256];
            n_total++;
            if (got !== NIST_T2 || tn[k] - tbase[k] !== 1)
                $display("FAIL nist2_tag dw%0d: got %h (%0d tags) want %h", dw_of(k), got, tn[k] - tbase[k], NIST_T2);
            else n_pass++;
            n_total++;
            if ((got ^ NIST_EK) !== NIST_Y2) $display("FAIL nist2_y dw%0d: got %h want %h", dw_of(k), got ^ NIST_EK, NIST_Y2); else n_pass++;
            n_total++;
            if (got !== ref_tag(NIST_H, 2, NIST_EK)) $display("FAIL nist2_model dw%0d: got %h want %h", dw_of(k), got, ref_tag(NIST_H, 2, NIST_EK)); else n_pass++;
        end
    endtask

    // Valid held high on the DIGIT_W=8 instance across both blocks of case 2.
    task automatic test_handshake();
        int beats, low1, low2, g; bit prev;
        load_h(NIST_H);
        msg[0] = NIST_C; msg[1] = NIST_LEN;
        snap();
        x = msg[0]; last = 1'b0; ek0 = NIST_EK; vld[1] = 1'b1;
        #1;
        prev = rdy[1]; beats = 0; low1 = 0; low2 = 0; g = 0;
        while (beats < 2 && g < 300) begin
            tick(); g++;
            if (prev) begin
                beats++;
                if (beats == 1) begin x = msg[1]; last = 1'b1; end
                else vld[1] = 1'b0;
            end
            if (beats == 1 && !rdy[1]) low1++;
            prev = rdy[1];
        end
        while (!rdy[1] && g < 300) begin low2++; tick(); g++; end
        n_total++;
        if (beats !== 2) $display("FAIL hs_beats: got %0d want 2", beats); else n_pass++;
        n_total++;
        if (low1 !== 16) $display("FAIL hs_ready_low_blk1: got %0d want 16", low1); else n_pass++;
        n_total++;
        if (low2 !== 16) $display("FAIL hs_ready_low_blk2: got %0d want 16", low2); else n_pass++;
        tick(); tick();
        n_total++;
        if (tn[1] - tbase[1] !== 1 || tlog[1][tbase[1] % 256] !== NIST_T2)
            $display("FAIL hs_tag: got %h (%0d tags) want %h", tlog[1][tbase[1] % 256], tn[1] - tbase[1], NIST_T2);
        else n_pass++;
        n_total++;
        if (tn[0] !== tbase[0] || tn[2] !== tbase[2])
            $display("FAIL hs_idle_instances: got %0d/%0d tags want 0/0", tn[0] - tbase[0], tn[2] - tbase[2]);
        else n_pass++;
    endtask

    task automatic test_illegal_load();
        int acc; bit ok;
        load_h(NIST_H);
        snap();
        send_beat(NIST_C, 1'b0, NIST_EK, 3'b111, acc, ok);
        h = rnd128(); h_load = 1'b1;
        tick();
        h_load = 1'b0;
        send_beat(NIST_LEN, 1'b1, NIST_EK, 3'b111, acc, ok);
        wait_tags(3'b111, ok);
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (tlog[k][tbase[k] % 256] !== NIST_T2)
                $display("FAIL busy_load_tag dw%0d: got %h want %h", dw_of(k), tlog[k][tbase[k] % 256], NIST_T2);
            else n_pass++;
        end
    endtask

    task automatic test_load_vs_valid();
        int acc; bit ok;
        logic [0:127] hn, ekv;
        hn = rnd128(); ekv = rnd128();
        h = hn; h_load = 1'b1; x = rnd128(); last = 1'b1; ek0 = rnd128();
        for (int k = 0; k < NI; k++) vld[k] = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (rdy[k] !== 1'b0) $display("FAIL load_win_ready dw%0d: got %b want 0", dw_of(k), rdy[k]); else n_pass++;
        end
        tick();
        h_load = 1'b0;
        for (int k = 0; k < NI; k++) vld[k] = 1'b0;
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (busy[k] !== 1'b0) $display("FAIL load_win_not_accepted dw%0d: got busy %b want 0", dw_of(k), busy[k]); else n_pass++;
        end
        msg[0] = rnd128(); msg[1] = rnd128();
        snap();
        send_msg(2, ekv, 3'b111, acc, ok);
        wait_tags(3'b111, ok);
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (tlog[k][tbase[k] % 256] !== ref_tag(hn, 2, ekv))
                $display("FAIL load_win_tag dw%0d: got %h want %h", dw_of(k), tlog[k][tbase[k] % 256], ref_tag(hn, 2, ekv));
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        int acc; bit ok;
        load_h(NIST_H);
        send_beat(NIST_C, 1'b0, NIST_EK, 3'b011, acc, ok);
        tick(); tick(); tick();
        snap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (rdy[k] !== 1'b1 || busy[k] !== 1'b0 || tv[k] !== 1'b0 || tag[k] !== 128'h0)
                $display("FAIL midreset_state dw%0d: got rdy %b busy %b tv %b tag %h want 1 0 0 0", dw_of(k), rdy[k], busy[k], tv[k], tag[k]);
            else n_pass++;
        end
        for (int i = 0; i < 150; i++) tick();
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (tn[k] !== tbase[k]) $display("FAIL midreset_no_tag dw%0d: got %0d tags want 0", dw_of(k), tn[k] - tbase[k]); else n_pass++;
        end
        load_h(NIST_H);
        msg[0] = NIST_C; msg[1] = NIST_LEN;
        snap();
        send_msg(2, NIST_EK, 3'b111, acc, ok);
        wait_tags(3'b111, ok);
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (tlog[k][tbase[k] % 256] !== NIST_T2)
                $display("FAIL midreset_rerun dw%0d: got %h want %h", dw_of(k), tlog[k][tbase[k] % 256], NIST_T2);
            else n_pass++;
        end
    endtask

    // Random keys and messages; two messages per key without reloading H.
    task automatic test_back_to_back();
        int acc, n; bit ok;
        logic [0:127] hv, ekv, exp;
        for (int it = 0; it < 4; it++) begin
            hv = rnd128();
            load_h(hv);
            for (int m = 0; m < 2; m++) begin
                n = $urandom_range(3, 1);
                for (int i = 0; i < n; i++) msg[i] = rnd128();
                ekv = rnd128();
                exp = ref_tag(hv, n, ekv);
                snap();
                send_msg(n, ekv, 3'b111, acc, ok);
                wait_tags(3'b111, ok);
                for (int k = 0; k < NI; k++) begin
                    n_total++;
                    if (tn[k] - tbase[k] !== 1 || tlog[k][tbase[k] % 256] !== exp)
                        $display("FAIL b2b_tag it%0d msg%0d dw%0d: got %h (%0d tags) want %h", it, m, dw_of(k),
                                 tlog[k][tbase[k] % 256], tn[k] - tbase[k], exp);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unit_element();
        test_nist1();
        test_nist2();
        test_handshake();
        test_illegal_load();
        test_load_vs_valid();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
